// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial weight interface: precision codes,
// the buffered word layout, and width decoding reused by the MAC lanes.
package bs_pkg;

  localparam logic [1:0] PREC_8 = 2'b00;
  localparam logic [1:0] PREC_4 = 2'b01;
  localparam logic [1:0] PREC_2 = 2'b10;

  // One buffered weight: precision code travels with its data word.
  typedef struct packed {
    logic [1:0] prec;
    logic [7:0] data;
  } bs_word_t;

  // Number of significant bits for a precision code (code 11 is 8 bits).
  function automatic logic [3:0] prec_nbits(input logic [1:0] code);
    case (code)
      PREC_4:  return 4'd4;
      PREC_2:  return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

  // Index of the sign bit, i.e. the last bit emitted for a word.
  function automatic logic [2:0] prec_last_idx(input logic [1:0] code);
    case (code)
      PREC_4:  return 3'd3;
      PREC_2:  return 3'd1;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/bs_word_fifo.sv
// Small synchronous FIFO of {prec, data} words. The caller guarantees it
// never pushes when full or pops when empty; push and pop may coincide.
module bs_word_fifo
  import bs_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push_i,
  input  bs_word_t push_word_i,
  input  logic     pop_i,
  output bs_word_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;
  bs_word_t    mem_q [DEPTH];

  // Word storage write port.
  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= push_word_i;
  end

  // Read/write pointer update.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/weight_bit_streamer.sv
// Bit-serial weight producer: buffers parallel weight words and streams each
// one LSB first, flagging the first bit (MAC clear) and the sign bit (MAC
// two's-complement correction) of every word.
module weight_bit_streamer
  import bs_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] w_data,
  input  logic [1:0] w_prec,
  input  logic       w_valid,
  output logic       w_ready,
  input  logic       s_ready,
  output logic       s_valid,
  output logic       s_bit,
  output logic       s_first,
  output logic       s_last,
  output logic [2:0] s_count,
  output logic [1:0] s_prec
);

  // Shifter state: current word, bit index and whether a word is in flight.
  bs_word_t cur_q, cur_d;
  logic [2:0] idx_q, idx_d;
  logic       busy_q, busy_d;

  bs_word_t fifo_head;
  logic     fifo_full, fifo_empty;
  logic     fifo_push, fifo_pop;
  logic     bypass;
  logic     accept;
  logic [2:0] last_idx;

  assign w_ready  = ~fifo_full;
  assign accept   = w_valid & w_ready;
  assign last_idx = prec_last_idx(cur_q.prec);

  // Words go to the FIFO unless they are loaded straight into the shifter.
  assign fifo_push = accept & ~bypass;

  bs_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rstn       (rstn),
    .push_i     (fifo_push),
    .push_word_i('{prec: w_prec, data: w_data}),
    .pop_i      (fifo_pop),
    .head_o     (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  // Next shifter state: advance the index, or on a free slot load the FIFO
  // head first, else bypass the word arriving this edge, else go idle.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cur_d    = cur_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    if (busy_q && s_ready && (idx_q != last_idx)) begin
      idx_d = idx_q + 1'b1;
    end else if (!busy_q || s_ready) begin
      idx_d = '0;
      if (!fifo_empty) begin
        cur_d    = fifo_head;
        busy_d   = 1'b1;
        fifo_pop = 1'b1;
      end else if (accept) begin
        cur_d  = '{prec: w_prec, data: w_data};
        busy_d = 1'b1;
        bypass = 1'b1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  // Shifter registers; reset discards the word in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      idx_q  <= idx_d;
      busy_q <= busy_d;
    end
  end

  // Stream outputs come straight from registers, gated by busy.
  assign s_valid = busy_q;
  assign s_bit   = busy_q & cur_q.data[idx_q];
  assign s_first = busy_q & (idx_q == 3'd0);
  assign s_last  = busy_q & (idx_q == last_idx);
  assign s_count = idx_q;
  assign s_prec  = cur_q.prec;

endmodule
